// File: rtl/bcd_display_mux_if.sv
// Bus between the BCD converter side and the display driver: digit load
// strobe with BCD digits in, multiplexed segment/anode drive out.
interface bcd_display_mux_if;
  logic       cargar;
  logic [3:0] Rcentenas;
  logic [3:0] Rdecenas;
  logic [3:0] Runidades;
  logic [6:0] seg;
  logic [2:0] an;
  logic       valido;

  modport master (
    output cargar, Rcentenas, Rdecenas, Runidades,
    input  seg, an, valido
  );

  modport slave (
    input  cargar, Rcentenas, Rdecenas, Runidades,
    output seg, an, valido
  );
endinterface

// File: rtl/bcd_display_mux.sv
// Three-digit multiplexed common-anode 7-segment driver with latched BCD
// digits, programmable per-digit dwell, leading-zero blanking and dash for bad codes.
module bcd_display_mux #(
  parameter int unsigned PRESCALE = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic              clk,
  input logic              rst,
  bcd_display_mux_if.slave bus
);
  localparam int unsigned   CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    SCAN_U = 2'd0,
    SCAN_T = 2'd1,
    SCAN_H = 2'd2
  } scan_t;

  scan_t         idx, idx_next;
  logic [CW-1:0] cnt;
  logic [3:0]    dC, dD, dU;
  logic          valido_q;
  logic [6:0]    seg_q, seg_next;
  logic [2:0]    an_q, an_next, an_sel;
  logic [3:0]    digit;
  logic          blank;
  logic          wrap;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      dC       <= '0;
      dD       <= '0;
      dU       <= '0;
      valido_q <= 1'b0;
      cnt      <= '0;
      idx      <= SCAN_U;
      seg_q    <= '1;
      an_q     <= '1;
    end else begin
      if (bus.cargar) begin
        dC       <= bus.Rcentenas;
        dD       <= bus.Rdecenas;
        dU       <= bus.Runidades;
        valido_q <= 1'b1;
      end
      cnt   <= wrap ? '0 : cnt + 1'b1;
      idx   <= idx_next;
      seg_q <= seg_next;
      an_q  <= an_next;
    end
  end

  // Outputs are registered from the current index/digits, so a load or an
  // index step shows up on the display one edge later, with an/seg in lockstep.
  always_comb begin
    wrap     = (cnt == CNT_MAX);
    idx_next = idx;
    digit    = dU;
    an_sel   = 3'b110;
    blank    = !valido_q;

    if (wrap) begin
      case (idx)
        SCAN_U:  idx_next = SCAN_T;
        SCAN_T:  idx_next = SCAN_H;
        default: idx_next = SCAN_U;
      endcase
    end

    case (idx)
      SCAN_T: begin
        digit  = dD;
        an_sel = 3'b101;
        if (BLANK_LZ && dC == 4'd0 && dD == 4'd0) blank = 1'b1;
      end
      SCAN_H: begin
        digit  = dC;
        an_sel = 3'b011;
        if (BLANK_LZ && dC == 4'd0) blank = 1'b1;
      end
      default: begin
        digit  = dU;
        an_sel = 3'b110;
      end
    endcase

    seg_next = blank ? 7'h7F : decode(digit);
    an_next  = blank ? 3'b111 : an_sel;
  end

  assign bus.seg    = seg_q;
  assign bus.an     = an_q;
  assign bus.valido = valido_q;
endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux: main (PRESCALE=4, blanking), no-blanking
// and PRESCALE=1 instances share stimulus and reset.
module tb_bcd_display_mux;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cargar = 1'b0;
  logic [3:0] c = '0, d = '0, u = '0;

  int ecount   = 0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_display_mux_if if_main ();
  bcd_display_mux_if if_nb ();
  bcd_display_mux_if if_p1 ();

  assign if_main.cargar = cargar;  assign if_main.Rcentenas = c;
  assign if_main.Rdecenas = d;     assign if_main.Runidades = u;
  assign if_nb.cargar = cargar;    assign if_nb.Rcentenas = c;
  assign if_nb.Rdecenas = d;       assign if_nb.Runidades = u;
  assign if_p1.cargar = cargar;    assign if_p1.Rcentenas = c;
  assign if_p1.Rdecenas = d;       assign if_p1.Runidades = u;

  bcd_display_mux #(.PRESCALE(4), .BLANK_LZ(1'b1)) dut (.clk(clk), .rst(rst), .bus(if_main));
  bcd_display_mux #(.PRESCALE(4), .BLANK_LZ(1'b0)) dut_nb (.clk(clk), .rst(rst), .bus(if_nb));
  bcd_display_mux #(.PRESCALE(1), .BLANK_LZ(1'b1)) dut_p1 (.clk(clk), .rst(rst), .bus(if_p1));

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SD = 7'b0111111, SX = 7'h7F;

  // Slot index 0 = units, 1 = tens, 2 = hundreds (packed {h,t,u}).
  typedef struct packed {
    logic [3:0]       c, d, u;
    logic [2:0][6:0]  seg;
    logic [2:0][2:0]  an;
    logic [2:0][6:0]  nb;
  } rec_t;

  localparam int NREC = 9;
  rec_t recs [NREC];
  logic [2:0][2:0] an_on;

  task automatic tick();
    @(posedge clk);
    if (rst) ecount = 0;
    else     ecount++;
    #1;
  endtask

  task automatic cmp(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, ecount, got, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    cmp({tag, " seg"}, if_main.seg, SX);
    cmp({tag, " an"}, {4'b0, if_main.an}, 7'b0000111);
    cmp({tag, " valido"}, {6'b0, if_main.valido}, 7'd0);
    cmp({tag, " nb seg"}, if_nb.seg, SX);
    cmp({tag, " nb an"}, {4'b0, if_nb.an}, 7'b0000111);
    cmp({tag, " p1 an"}, {4'b0, if_p1.an}, 7'b0000111);
  endtask

  task automatic check_slot(input int i, input string tag);
    int s4, s1;
    s4 = ((ecount - 1) / 4) % 3;
    s1 = (ecount - 1) % 3;
    cmp({tag, " seg"}, if_main.seg, recs[i].seg[s4]);
    cmp({tag, " an"}, {4'b0, if_main.an}, {4'b0, recs[i].an[s4]});
    cmp({tag, " nb seg"}, if_nb.seg, recs[i].nb[s4]);
    cmp({tag, " nb an"}, {4'b0, if_nb.an}, {4'b0, an_on[s4]});
    cmp({tag, " p1 seg"}, if_p1.seg, recs[i].seg[s1]);
    cmp({tag, " p1 an"}, {4'b0, if_p1.an}, {4'b0, recs[i].an[s1]});
    cmp({tag, " valido"}, {6'b0, if_main.valido}, 7'd1);
  endtask

  task automatic load(input int i);
    c = recs[i].c; d = recs[i].d; u = recs[i].u;
    cargar = 1'b1;
    tick();
    cargar = 1'b0;
  endtask

  task automatic check_frame(input int i, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      check_slot(i, tag);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    an_on   = {3'b011, 3'b101, 3'b110};
    recs[0] = '{4'd0, 4'd1, 4'd9, {SX, S1, S9}, {3'b111, 3'b101, 3'b110}, {S0, S1, S9}};
    recs[1] = '{4'd1, 4'hA, 4'd3, {S1, SD, S3}, {3'b011, 3'b101, 3'b110}, {S1, SD, S3}};
    recs[2] = '{4'd0, 4'd0, 4'd0, {SX, SX, S0}, {3'b111, 3'b111, 3'b110}, {S0, S0, S0}};
    recs[3] = '{4'd7, 4'd0, 4'd5, {S7, S0, S5}, {3'b011, 3'b101, 3'b110}, {S7, S0, S5}};
    recs[4] = '{4'd0, 4'hF, 4'd8, {SX, SD, S8}, {3'b111, 3'b101, 3'b110}, {S0, SD, S8}};
    recs[5] = '{4'd4, 4'd6, 4'd2, {S4, S6, S2}, {3'b011, 3'b101, 3'b110}, {S4, S6, S2}};
    recs[6] = '{4'd5, 4'd1, 4'd1, {S5, S1, S1}, {3'b011, 3'b101, 3'b110}, {S5, S1, S1}};
    recs[7] = '{4'd2, 4'd2, 4'd2, {S2, S2, S2}, {3'b011, 3'b101, 3'b110}, {S2, S2, S2}};
    recs[8] = '{4'd0, 4'd0, 4'hE, {SX, SX, SD}, {3'b111, 3'b111, 3'b110}, {S0, S0, SD}};

    // Reset and idle: dark, not valid.
    rst = 1'b1;
    repeat (3) tick();
    check_dark("reset");
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      check_dark("idle");
    end

    // Table: one-cycle load, then a full frame checked per cycle.
    for (int i = 0; i < NREC; i++) begin
      load(i);
      check_frame(i, 12, "table");
    end

    // Reload one cycle into a dwell: 5,1,1 visible for exactly one cycle.
    for (int k = 0; k < 4 && (ecount % 4) != 1; k++) tick();
    c = 4'd5; d = 4'd1; u = 4'd1; cargar = 1'b1;
    tick();
    c = 4'd0; d = 4'd0; u = 4'd0;
    tick();
    cargar = 1'b0;
    check_slot(6, "midload first");
    tick();
    check_slot(2, "midload zero");
    check_frame(2, 12, "midload frame");

    // Reset together with a load, 5 cycles into a frame.
    load(6);
    check_frame(6, 3, "pre-rst");
    for (int k = 0; k < 12 && (ecount % 12) != 5; k++) tick();
    rst = 1'b1; cargar = 1'b1; c = 4'd2; d = 4'd2; u = 4'd2;
    tick();
    check_dark("rst+load");
    rst = 1'b0; cargar = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      check_dark("post-rst");
    end
    load(7);
    check_frame(7, 12, "after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
